// File: rtl/decode_pkg.sv
// Shared types and encodings for the RV32I decode stage.
package decode_pkg;

  localparam int unsigned DATA_W = 32;
  localparam int unsigned ILEN   = 32;

  typedef enum logic [4:0] {
    ALU_ADD   = 5'd0,
    ALU_SUB   = 5'd1,
    ALU_SLL   = 5'd2,
    ALU_SLT   = 5'd3,
    ALU_SLTU  = 5'd4,
    ALU_XOR   = 5'd5,
    ALU_SRL   = 5'd6,
    ALU_SRA   = 5'd7,
    ALU_OR    = 5'd8,
    ALU_AND   = 5'd9,
    ALU_PASSB = 5'd10
  } alu_op_t;

  localparam logic [6:0] OPC_OP    = 7'b0110011;
  localparam logic [6:0] OPC_OPIMM = 7'b0010011;
  localparam logic [6:0] OPC_LUI   = 7'b0110111;

  localparam logic [6:0] F7_BASE = 7'b0000000;
  localparam logic [6:0] F7_ALT  = 7'b0100000;

  typedef struct packed {
    logic [DATA_W-1:0] pc;
    logic [6:0]        opcode;
    logic [4:0]        rd;
    logic [4:0]        rs1;
    logic [4:0]        rs2;
    logic [DATA_W-1:0] imm;
    logic              use_imm;
    alu_op_t           alu_op;
    logic              reg_write;
    logic              illegal;
  } decoded_t;

  // funct3 -> ALU operation for the funct7=base flavour of OP/OP-IMM
  function automatic alu_op_t f3_op(input logic [2:0] f3);
    alu_op_t op;
    case (f3)
      3'b000:  op = ALU_ADD;
      3'b001:  op = ALU_SLL;
      3'b010:  op = ALU_SLT;
      3'b011:  op = ALU_SLTU;
      3'b100:  op = ALU_XOR;
      3'b101:  op = ALU_SRL;
      3'b110:  op = ALU_OR;
      default: op = ALU_AND;
    endcase
    return op;
  endfunction

endpackage

// File: rtl/decode_stage_decoder.sv
// Purely combinational RV32I field/immediate decoder (OP, OP-IMM, LUI).
module instr_decoder
  import decode_pkg::*;
(
  input  logic [ILEN-1:0] in_instr,
  output decoded_t        dec
);

  logic [6:0] opcode;
  logic [2:0] f3;
  logic [6:0] f7;
  logic [4:0] rd;
  logic       legal;

  assign opcode = in_instr[6:0];
  assign rd     = in_instr[11:7];
  assign f3     = in_instr[14:12];
  assign f7     = in_instr[31:25];

  always_comb begin
    dec        = '0;
    legal      = 1'b0;
    dec.opcode = opcode;
    dec.rd     = rd;
    dec.rs1    = in_instr[19:15];
    dec.rs2    = in_instr[24:20];
    dec.alu_op = ALU_ADD;

    case (opcode)
      OPC_OP: begin
        dec.alu_op = f3_op(f3);
        if (f7 == F7_BASE) begin
          legal = 1'b1;
        end else if (f7 == F7_ALT && (f3 == 3'b000 || f3 == 3'b101)) begin
          legal      = 1'b1;
          dec.alu_op = (f3 == 3'b000) ? ALU_SUB : ALU_SRA;
        end
      end
      OPC_OPIMM: begin
        dec.use_imm = 1'b1;
        dec.alu_op  = f3_op(f3);
        case (f3)
          3'b001: begin
            legal   = (f7 == F7_BASE);
            dec.imm = DATA_W'(in_instr[24:20]);
          end
          3'b101: begin
            dec.imm = DATA_W'(in_instr[24:20]);
            if (f7 == F7_BASE) begin
              legal = 1'b1;
            end else if (f7 == F7_ALT) begin
              legal      = 1'b1;
              dec.alu_op = ALU_SRA;
            end
          end
          default: begin
            legal   = 1'b1;
            dec.imm = {{(DATA_W-12){in_instr[31]}}, in_instr[31:20]};
          end
        endcase
      end
      OPC_LUI: begin
        legal       = 1'b1;
        dec.use_imm = 1'b1;
        dec.alu_op  = ALU_PASSB;
        dec.rs1     = 5'd0;
        dec.imm     = {in_instr[31:12], 12'h000};
      end
      default: ;
    endcase

    // Illegal bundles still flow, but must be inert downstream
    if (!legal) begin
      dec.alu_op  = ALU_ADD;
      dec.imm     = '0;
      dec.use_imm = 1'b0;
    end
    dec.illegal   = !legal;
    dec.reg_write = legal && (rd != 5'd0);
  end

endmodule

// File: rtl/decode_stage.sv
// Registered decode stage: decoder, 2-entry skid buffer and illegal-instruction counter.
module decode_stage
  import decode_pkg::*;
#(
  parameter int unsigned XLEN  = 32,
  parameter int unsigned CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             flush,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [31:0]      in_instr,
  input  logic [XLEN-1:0]  in_pc,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [XLEN-1:0]  out_pc,
  output logic [6:0]       out_opcode,
  output logic [4:0]       out_rd,
  output logic [4:0]       out_rs1,
  output logic [4:0]       out_rs2,
  output logic [XLEN-1:0]  out_imm,
  output logic             out_use_imm,
  output logic [4:0]       out_alu_op,
  output logic             out_reg_write,
  output logic             out_illegal,
  output logic [CNT_W-1:0] illegal_count
);

  decoded_t dec;
  decoded_t new_b;
  decoded_t main_q, main_d;
  decoded_t skid_q, skid_d;
  logic     main_valid_q, main_valid_d;
  logic     skid_valid_q, skid_valid_d;
  logic     in_ready_q, in_ready_d;
  logic     accept;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  instr_decoder u_decoder (
    .in_instr (in_instr),
    .dec      (dec)
  );

  assign accept = in_valid && in_ready_q;

  // Next-state for the two buffer entries and the counter
  always_comb begin
    new_b        = dec;
    new_b.pc     = DATA_W'(in_pc);
    main_d       = main_q;
    skid_d       = skid_q;
    main_valid_d = main_valid_q;
    skid_valid_d = skid_valid_q;
    cnt_d        = cnt_q;

    if (flush) begin
      main_valid_d = 1'b0;
      skid_valid_d = 1'b0;
    end else begin
      if (!main_valid_q || out_ready) begin
        // in_ready is low whenever skid is full, so no accept competes here
        if (skid_valid_q) begin
          main_d       = skid_q;
          main_valid_d = 1'b1;
          skid_valid_d = 1'b0;
        end else if (accept) begin
          main_d       = new_b;
          main_valid_d = 1'b1;
        end else begin
          main_valid_d = 1'b0;
        end
      end else if (accept) begin
        skid_d       = new_b;
        skid_valid_d = 1'b1;
      end

      if (accept && new_b.illegal && (cnt_q != '1)) begin
        cnt_d = cnt_q + CNT_W'(1);
      end
    end

    in_ready_d = !skid_valid_d;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      main_q       <= '0;
      skid_q       <= '0;
      main_valid_q <= 1'b0;
      skid_valid_q <= 1'b0;
      in_ready_q   <= 1'b1;
      cnt_q        <= '0;
    end else begin
      main_q       <= main_d;
      skid_q       <= skid_d;
      main_valid_q <= main_valid_d;
      skid_valid_q <= skid_valid_d;
      in_ready_q   <= in_ready_d;
      cnt_q        <= cnt_d;
    end
  end

  assign in_ready      = in_ready_q;
  assign out_valid     = main_valid_q;
  assign out_pc        = XLEN'(main_q.pc);
  assign out_opcode    = main_q.opcode;
  assign out_rd        = main_q.rd;
  assign out_rs1       = main_q.rs1;
  assign out_rs2       = main_q.rs2;
  assign out_imm       = XLEN'(main_q.imm);
  assign out_use_imm   = main_q.use_imm;
  assign out_alu_op    = main_q.alu_op;
  assign out_reg_write = main_q.reg_write;
  assign out_illegal   = main_q.illegal;
  assign illegal_count = cnt_q;

endmodule

// File: tb/tb_decode_stage.sv
// Scoreboard bench for decode_stage: directed plan vectors, then randomized traffic.
module tb_decode_stage;

  localparam int unsigned CNT_W   = 8;
  localparam int unsigned CNT_MAX = (1 << CNT_W) - 1;

  logic             clk = 1'b0;
  logic             rst, flush, in_valid, out_ready;
  logic             in_ready, out_valid;
  logic [31:0]      in_instr, in_pc;
  logic [31:0]      out_pc, out_imm;
  logic [6:0]       out_opcode;
  logic [4:0]       out_rd, out_rs1, out_rs2, out_alu_op;
  logic             out_use_imm, out_reg_write, out_illegal;
  logic [CNT_W-1:0] illegal_count;

  decode_stage #(.XLEN(32), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst(rst), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready), .in_instr(in_instr), .in_pc(in_pc),
    .out_valid(out_valid), .out_ready(out_ready), .out_pc(out_pc),
    .out_opcode(out_opcode), .out_rd(out_rd), .out_rs1(out_rs1), .out_rs2(out_rs2),
    .out_imm(out_imm), .out_use_imm(out_use_imm), .out_alu_op(out_alu_op),
    .out_reg_write(out_reg_write), .out_illegal(out_illegal),
    .illegal_count(illegal_count)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] pc;
    logic [6:0]  opc;
    logic [4:0]  rd, rs1, rs2;
    logic [31:0] imm;
    logic        use_imm;
    logic [4:0]  alu;
    logic        rw;
    logic        ill;
  } exp_t;

  exp_t        exp_q[$];
  int          tests = 0;
  int          fails = 0;
  int unsigned cnt_m = 0;

  // Reference decode from the ISA rules; alternate funct7 bumps ADD->SUB and SRL->SRA
  function automatic exp_t model(input logic [31:0] i, input logic [31:0] pc);
    exp_t       e;
    logic [2:0] f3 = i[14:12];
    logic [6:0] f7 = i[31:25];
    bit         alt = (f7 == 7'h20);
    bit         legal = 1'b0;
    int         base_op[8] = '{0, 2, 3, 4, 5, 6, 8, 9};
    e.pc = pc; e.opc = i[6:0]; e.rd = i[11:7]; e.rs1 = i[19:15]; e.rs2 = i[24:20];
    e.imm = 0; e.use_imm = 0; e.alu = 0;
    case (i[6:0])
      7'h33: begin
        legal = (f7 == 0) || (alt && (f3 == 0 || f3 == 5));
        e.alu = 5'(base_op[f3] + (alt ? 1 : 0));
      end
      7'h13: begin
        e.use_imm = 1;
        if (f3 == 1) legal = (f7 == 0);
        else if (f3 == 5) legal = (f7 == 0) || alt;
        else legal = 1;
        e.alu = 5'(base_op[f3] + ((f3 == 5 && alt) ? 1 : 0));
        if (f3 == 1 || f3 == 5) e.imm = 32'(i[24:20]);
        else e.imm = i[31] ? (32'(i[31:20]) - 32'd4096) : 32'(i[31:20]);
      end
      7'h37: begin
        legal = 1; e.alu = 10; e.use_imm = 1; e.rs1 = 0;
        e.imm = i & 32'hFFFF_F000;
      end
      default: ;
    endcase
    if (!legal) begin e.alu = 0; e.imm = 0; e.use_imm = 0; end
    e.ill = !legal;
    e.rw  = legal && (e.rd != 0);
    return e;
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // One cycle: check occupancy-derived outputs, drive inputs, record accepted work
  task automatic step(input bit v, input logic [31:0] instr, input logic [31:0] pc,
                      input bit ordy, input bit fl, input bit rs, output bit acc);
    exp_t e;
    @(negedge clk);
    chk("out_valid", 64'(out_valid), 64'(exp_q.size() > 0));
    chk("in_ready", 64'(in_ready), 64'(exp_q.size() < 2));
    chk("illegal_count", 64'(illegal_count), 64'(cnt_m));
    in_valid = v; in_instr = instr; in_pc = pc; out_ready = ordy; flush = fl; rst = rs;
    #1;
    acc = v && in_ready && !fl && !rs;
    if (acc) begin
      e = model(instr, pc);
      exp_q.push_back(e);
      if (e.ill && cnt_m < CNT_MAX) cnt_m++;
    end
    if (rs) cnt_m = 0;
  endtask

  function automatic logic [31:0] rand_instr();
    logic [31:0] r = $urandom;
    case ($urandom % 5)
      0, 1: r[6:0] = 7'h33;
      2, 3: r[6:0] = 7'h13;
      default: if ($urandom % 2 == 0) r[6:0] = 7'h37;
    endcase
    case ($urandom % 3)
      0: r[31:25] = 7'h00;
      1: r[31:25] = 7'h20;
      default: ;
    endcase
    return r;
  endfunction

  // Monitor: compares the presented bundle every cycle, pops on handshake
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      #2;
      if (out_valid) begin
        if (exp_q.size() == 0) begin
          tests++; fails++;
          $display("FAIL out_unexpected: bundle pc=%0h with nothing expected", out_pc);
        end else begin
          e = exp_q[0];
          chk("out_pc", 64'(out_pc), 64'(e.pc));
          chk("out_opcode", 64'(out_opcode), 64'(e.opc));
          chk("out_rd", 64'(out_rd), 64'(e.rd));
          chk("out_rs1", 64'(out_rs1), 64'(e.rs1));
          chk("out_rs2", 64'(out_rs2), 64'(e.rs2));
          chk("out_imm", 64'(out_imm), 64'(e.imm));
          chk("out_use_imm", 64'(out_use_imm), 64'(e.use_imm));
          chk("out_alu_op", 64'(out_alu_op), 64'(e.alu));
          chk("out_reg_write", 64'(out_reg_write), 64'(e.rw));
          chk("out_illegal", 64'(out_illegal), 64'(e.ill));
          if (out_ready) void'(exp_q.pop_front());
        end
      end
      if (flush || rst) exp_q.delete();
    end
  end

  task automatic chk_zero_outputs(input string tag);
    chk({tag, "_out_valid"}, 64'(out_valid), 64'd0);
    chk({tag, "_out_pc"}, 64'(out_pc), 64'd0);
    chk({tag, "_out_rd_rs"}, 64'({out_opcode, out_rd, out_rs1, out_rs2}), 64'd0);
    chk({tag, "_out_imm"}, 64'(out_imm), 64'd0);
    chk({tag, "_out_flags"}, 64'({out_use_imm, out_alu_op, out_reg_write, out_illegal}), 64'd0);
    chk({tag, "_illegal_count"}, 64'(illegal_count), 64'd0);
  endtask

  initial begin
    logic [31:0] plan[7];
    logic [31:0] bp[4];
    logic [31:0] pc;
    bit          acc;
    int          idx;

    rst = 1; flush = 0; in_valid = 0; out_ready = 0; in_instr = 0; in_pc = 0;
    pc  = 32'h1000;
    step(0, 0, 0, 0, 0, 1, acc);
    step(0, 0, 0, 0, 0, 1, acc);
    step(0, 0, 0, 1, 0, 0, acc);
    chk_zero_outputs("reset");

    // Plan vectors back-to-back with downstream always ready
    plan = '{32'h002081B3, 32'h402081B3, 32'h4030D093, 32'hFFF00293,
             32'h123450B7, 32'h00000000, 32'h022080B3};
    foreach (plan[k]) begin
      step(1, plan[k], pc, 1, 0, 0, acc);
      pc += 4;
    end
    step(0, 0, 0, 1, 0, 0, acc);
    step(0, 0, 0, 1, 0, 0, acc);
    chk("illegal_count_two", 64'(illegal_count), 64'd2);

    // Backpressure: four instructions, out_ready low for three cycles
    bp  = '{32'h00500093, 32'h00308133, 32'h40C5D513, 32'hABCDE237};
    idx = 0;
    for (int c = 0; c < 10; c++) begin
      step(idx < 4, (idx < 4) ? bp[idx] : 32'h0, pc, c >= 3, 0, 0, acc);
      if (acc) begin idx++; pc += 4; end
    end
    chk("backpressure_accepts", 64'(idx), 64'd4);

    // Flush with both entries full and a new instruction offered
    step(1, 32'h00108093, pc, 0, 0, 0, acc); pc += 4;
    step(1, 32'h00210113, pc, 0, 0, 0, acc); pc += 4;
    step(1, 32'h00318193, pc, 0, 1, 0, acc);
    step(0, 0, 0, 1, 0, 0, acc);
    step(0, 0, 0, 1, 0, 0, acc);

    // Reset mid-stream
    step(1, 32'h00000013, pc, 0, 0, 0, acc); pc += 4;
    step(1, 32'hFFFFFFFF, pc, 0, 0, 0, acc); pc += 4;
    step(1, 32'h00000033, pc, 0, 0, 1, acc);
    step(0, 0, 0, 1, 0, 0, acc);
    chk_zero_outputs("midrst");

    // Drive the counter into saturation
    for (int c = 0; c < CNT_MAX + 20; c++) begin
      step(1, 32'(($urandom & 32'hFFFF_FF80) | 32'h7F), pc, 1, 0, 0, acc);
      pc += 4;
    end
    step(0, 0, 0, 1, 0, 0, acc);
    chk("illegal_count_sat", 64'(illegal_count), 64'(CNT_MAX));

    // Randomized traffic with occasional flush and reset
    for (int c = 0; c < 3000; c++) begin
      step(($urandom % 4) != 0, rand_instr(), pc, ($urandom % 4) != 0,
           ($urandom % 60) == 0, ($urandom % 400) == 0, acc);
      if (acc) pc += 4;
    end
    for (int c = 0; c < 4; c++) step(0, 0, 0, 1, 0, 0, acc);
    chk("final_drain", 64'(exp_q.size()), 64'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/decode_stage.md
Name: decode_stage

Overview:
Registered instruction-decode stage directly upstream of the execute/ALU control path. Accepts 32-bit RV32I instructions over a valid/ready handshake and splits them into register indices and a sign-extended immediate. Resolves ADD vs SUB and SRL vs SRA from funct7, so downstream receives a complete alu_op. A 2-entry skid buffer gives full throughput under backpressure, and a saturating counter tracks illegal instructions.

Parameters:
XLEN, 32, datapath/immediate/pc width
CNT_W, 16, width of saturating illegal-instruction counter

Ports:
clk  in  1  clock, rising edge
rst  in  1  synchronous reset, active-high
flush  in  1  discard all held instructions
in_valid  in  1  instruction presented
in_ready  out  1  stage can accept
in_instr  in  32  raw instruction
in_pc  in  XLEN  instruction address
out_valid  out  1  decoded bundle valid
out_ready  in  1  downstream accepts
out_pc  out  XLEN  pc of bundle
out_opcode  out  7  instr[6:0]
out_rd / out_rs1 / out_rs2  out  5 each  register indices
out_imm  out  XLEN  sign-extended immediate
out_use_imm  out  1  ALU operand B = imm
out_alu_op  out  5  ALU operation code
out_reg_write  out  1  write rd
out_illegal  out  1  unsupported encoding
illegal_count  out  CNT_W  saturating count of accepted illegal instrs

Behaviour:
- Reset (rst=1 at posedge): out_valid=0, both buffer entries invalid, illegal_count=0. All out_* data fields are 0. in_ready is 1 from the first cycle after reset.
- Decode is combinational on in_instr. The result is written into the main register on accept (in_valid&&in_ready). Latency is 1 cycle, input accept to out_valid.
- Skid buffer behaviour:
  - in_ready = !skid_valid.
  - If main holds a bundle, out_ready=0, and a new accept occurs, the new bundle goes to skid.
  - When main drains, skid moves to main on the same edge.
  - Order is preserved. No bundle is dropped or duplicated. Sustained 1 instr/cycle when out_ready=1.
- out_* fields must stay stable while out_valid=1 and out_ready=0.
- Simultaneous drain+accept with skid empty: the new bundle replaces main. out_valid stays 1.
- flush: at the next edge both entries are invalidated and out_valid=0. An accept in the same cycle is discarded. in_ready=1 on the following cycle.
- rst overrides flush and everything else.
- Supported encodings:
  - opcode 0110011 (R-type): ADD/SUB/SLL/SLT/SLTU/XOR/SRL/SRA/OR/AND. funct7 must be 0000000, except SUB/SRA which require 0100000. use_imm=0.
  - opcode 0010011 (I-type): ADDI/SLTI/SLTIU/XORI/ORI/ANDI/SLLI/SRLI/SRAI. Immediate is instr[31:20] sign-extended. SLLI/SRLI require funct7=0000000 and SRAI requires 0100000. Shift imm = zero-extended instr[24:20]. use_imm=1.
  - opcode 0110111 (LUI): imm={instr[31:12],12'b0}, alu_op=PASSB, use_imm=1, rs1=0.
- reg_write=1 for legal instructions with rd!=0. reg_write=0 for rd=0 and for any illegal instruction.
- Illegal means any other opcode or funct combination:
  - out_illegal=1, alu_op=ADD, reg_write=0, imm=0, and the bundle still flows through.
  - illegal_count increments on accept of an illegal instruction. It saturates at all-ones and is not cleared by flush.

Decomposition:
- Package decode_pkg holds:
  - alu_op_t enum (5 bits): ADD=0, SUB=1, SLL=2, SLT=3, SLTU=4, XOR=5, SRL=6, SRA=7, OR=8, AND=9, PASSB=10.
  - Opcode constants OPC_OP=7'b0110011, OPC_OPIMM=7'b0010011, OPC_LUI=7'b0110111.
  - funct7 constants F7_BASE and F7_ALT.
  - decoded_t struct (pc, opcode, rd, rs1, rs2, imm, use_imm, alu_op, reg_write, illegal).
- Sub-module instr_decoder is purely combinational: in_instr in, decoded_t out. decode_stage instantiates it and owns the skid buffer and counter.

Test Plan:
- 0x002081B3 (add x3,x1,x2), out_ready=1 -> one cycle later: out_valid=1, rd=3, rs1=1, rs2=2, alu_op=ADD, reg_write=1, use_imm=0, illegal=0.
- 0x402081B3 (sub), then 0x4030D093 (srai x1,x1,3) -> alu_op=SUB, then alu_op=SRA with imm=3 and use_imm=1.
- 0xFFF00293 (addi x5,x0,-1) -> imm=0xFFFFFFFF, alu_op=ADD. 0x123450B7 (lui x1,0x12345) -> imm=0x12345000, alu_op=PASSB, reg_write=1.
- Backpressure: stream 4 instrs back-to-back, hold out_ready=0 for 3 cycles -> in_ready falls after 2 accepts, outputs stay stable. Then release -> all 4 emerge in order with no gaps.
- Illegal: 0x00000000 and 0x002080B3|(7'b0000001<<25) -> out_illegal=1, reg_write=0, illegal_count=2. Force counter near max -> saturates at 0xFFFF.
- flush with both entries full and in_valid=1 -> next cycle out_valid=0, in_ready=1, nothing emitted. rst mid-stream -> all outputs 0.
